ascii_hex_cmd_parser: RTL and testbench

//  Consumes received bytes from the UART RX stage and assembles CR-terminated ASCII hex commands.

---
 rtl/ascii_hex_cmd_parser_pkg.sv | 37 +++
 rtl/ascii_hex_cmd_parser_if.sv | 35 +++
 rtl/ascii_hex_cmd_parser_hex_ascii_decode.sv | 29 ++
 rtl/ascii_hex_cmd_parser.sv | 176 +++++++++++++++++
 tb/tb_ascii_hex_cmd_parser.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_hex_cmd_parser_pkg.sv
// Shared constants and types for the ASCII hex command parser.
//   - ASCII control/response characters
//   - response state encoding and response-byte index type
//   - resp_byte(): maps (success, index) onto the "OK<CR><LF>" or "ER<CR><LF>" response
package ascii_hex_cmd_parser_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiBs = 8'h08;
  localparam logic [7:0] AsciiSp = 8'h20;
  localparam logic [7:0] AsciiO  = 8'h4F;
  localparam logic [7:0] AsciiK  = 8'h4B;
  localparam logic [7:0] AsciiE  = 8'h45;
  localparam logic [7:0] AsciiR  = 8'h52;

  typedef enum logic [0:0] {
    StCollect,
    StResp
  } state_e;

  typedef logic [1:0] resp_idx_t;

  localparam resp_idx_t RespIdxLast = 2'd3;

  // Response ROM: byte idx of "OK<CR><LF>" (ok=1) or "ER<CR><LF>" (ok=0).
  function automatic logic [7:0] resp_byte(input logic ok, input resp_idx_t idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = ok ? AsciiO : AsciiE;
      2'd1:    b = ok ? AsciiK : AsciiR;
      2'd2:    b = AsciiCr;
      default: b = AsciiLf;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ascii_hex_cmd_parser_if.sv
// Bus bundle between the UART byte stream, the command parser and the display/TX side.
//   rx_data/rx_valid   : received byte strobe (into parser)
//   rx_drop            : byte discarded while busy (out of parser)
//   value/value_valid  : accepted command value and its update pulse
//   digit_cnt          : digits collected in the current command
//   cmd_err            : errored-command pulse
//   tx_data/tx_valid   : response byte stream (out of parser), tx_ready back-pressure (in)
// Modports: slave = parser view, master = environment view.
interface ascii_hex_cmd_parser_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned VALUE_W = 4 * DIGITS;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_drop;
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic [2:0]         digit_cnt;
  logic               cmd_err;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_drop, value, value_valid, digit_cnt, cmd_err, tx_data, tx_valid
  );

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_drop, value, value_valid, digit_cnt, cmd_err, tx_data, tx_valid
  );

endinterface

// File: rtl/ascii_hex_cmd_parser_hex_ascii_decode.sv
// Combinational ASCII hex character decoder.
//   byte_i   : input character
//   is_hex_o : 1 for '0'-'9', 'A'-'F', 'a'-'f'
//   nibble_o : decoded value (0 when not hex)
module ascii_hex_cmd_parser_hex_ascii_decode (
  input  logic [7:0] byte_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      // '0'..'9'
      is_hex_o = 1'b1;
      nibble_o = 4'(byte_i - 8'h30);
    end else if (byte_i >= 8'h41 && byte_i <= 8'h46) begin
      // 'A'..'F' -> 10..15
      is_hex_o = 1'b1;
      nibble_o = 4'(byte_i - 8'h37);
    end else if (byte_i >= 8'h61 && byte_i <= 8'h66) begin
      // 'a'..'f' -> 10..15
      is_hex_o = 1'b1;
      nibble_o = 4'(byte_i - 8'h57);
    end
  end

endmodule

// File: rtl/ascii_hex_cmd_parser.sv
// ASCII hex command parser: assembles CR-terminated commands of 1..DIGITS hex digits from the
// UART RX byte stream and presents the value to the display driver.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus_io : ascii_hex_cmd_parser_if.slave (rx stream in, value/status out, tx response out)
// Parameters: DIGITS (max digits, value width 4*DIGITS), CR_CHAR (terminator).
// Build option: define ASCII_HEX_ACK_EN to build the OK/ER <CR><LF> response path and rx_drop;
// otherwise tx_data/tx_valid/rx_drop are tied low and tx_ready is ignored.
module ascii_hex_cmd_parser
  import ascii_hex_cmd_parser_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter logic [7:0]  CR_CHAR = 8'h0D
) (
  input logic                   clk,
  input logic                   rst_n,
  ascii_hex_cmd_parser_if.slave bus_io
);

  localparam int unsigned VALUE_W = 4 * DIGITS;
  localparam logic [2:0]  MaxCnt  = 3'(DIGITS);

  logic [VALUE_W-1:0] acc_q, acc_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               value_valid_q, value_valid_d;
  logic               cmd_err_q, cmd_err_d;

  logic               busy;
  logic               rx_take;
  logic               is_hex;
  logic [3:0]         nibble;

  ascii_hex_cmd_parser_hex_ascii_decode u_decode (
    .byte_i   (bus_io.rx_data),
    .is_hex_o (is_hex),
    .nibble_o (nibble)
  );

  // Bytes arriving while a response is in flight never reach the collector.
  assign rx_take = bus_io.rx_valid && !busy;

  // Command collector datapath.
  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    cmd_err_d     = 1'b0;
    if (rx_take) begin
      if (bus_io.rx_data == CR_CHAR) begin
        acc_d = '0;
        cnt_d = 3'd0;
        err_d = 1'b0;
        if (err_q) begin
          cmd_err_d = 1'b1;
        end else if (cnt_q != 3'd0) begin
          value_d       = acc_q;
          value_valid_d = 1'b1;
        end
      end else if (is_hex) begin
        if (!err_q) begin
          if (cnt_q < MaxCnt) begin
            acc_d = (acc_q << 4) | VALUE_W'(nibble);
            cnt_d = cnt_q + 3'd1;
          end else begin
            // Overflow: keep the collected digits, poison the command.
            err_d = 1'b1;
          end
        end
      end else if (bus_io.rx_data == AsciiBs) begin
        if (!err_q && cnt_q != 3'd0) begin
          acc_d = acc_q >> 4;
          cnt_d = cnt_q - 3'd1;
        end
      end else if (bus_io.rx_data == AsciiLf || bus_io.rx_data == AsciiSp) begin
        // Whitespace is ignored.
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      cnt_q         <= 3'd0;
      err_q         <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign bus_io.value       = value_q;
  assign bus_io.value_valid = value_valid_q;
  assign bus_io.digit_cnt   = cnt_q;
  assign bus_io.cmd_err     = cmd_err_q;

`ifdef ASCII_HEX_ACK_EN

  state_e    state_q, state_d;
  logic      resp_ok_q, resp_ok_d;
  resp_idx_t idx_q, idx_d;
  logic      rx_drop_q, rx_drop_d;

  always_comb begin
    state_d   = state_q;
    resp_ok_d = resp_ok_q;
    idx_d     = idx_q;
    rx_drop_d = 1'b0;
    unique case (state_q)
      StCollect: begin
        // Only CRs that produce a pulse get a response; an empty command stays silent.
        if (value_valid_d || cmd_err_d) begin
          state_d   = StResp;
          resp_ok_d = value_valid_d;
          idx_d     = '0;
        end
      end
      StResp: begin
        rx_drop_d = bus_io.rx_valid;
        if (bus_io.tx_ready) begin
          if (idx_q == RespIdxLast) begin
            state_d = StCollect;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      resp_ok_q <= 1'b0;
      idx_q     <= '0;
      rx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      resp_ok_q <= resp_ok_d;
      idx_q     <= idx_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign busy            = (state_q == StResp);
  assign bus_io.tx_valid = busy;
  assign bus_io.tx_data  = busy ? resp_byte(resp_ok_q, idx_q) : 8'h00;
  assign bus_io.rx_drop  = rx_drop_q;

`else

  logic unused_tx_ready;

  assign unused_tx_ready = bus_io.tx_ready;
  assign busy            = 1'b0;
  assign bus_io.tx_valid = 1'b0;
  assign bus_io.tx_data  = 8'h00;
  assign bus_io.rx_drop  = 1'b0;

`endif

endmodule

// File: tb/tb_ascii_hex_cmd_parser.sv
module tb_ascii_hex_cmd_parser;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned VALUE_W = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ascii_hex_cmd_parser_if #(.DIGITS(DIGITS)) bus ();

  ascii_hex_cmd_parser #(
    .DIGITS  (DIGITS),
    .CR_CHAR (8'h0D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: the current command as a list of digit values plus an error flag.
  int                 m_digits[$];
  bit                 m_err   = 1'b0;
  logic [VALUE_W-1:0] m_value = '0;
  int unsigned        exp_vv   = 0;
  int unsigned        exp_err  = 0;
  int unsigned        exp_drop = 0;

  int unsigned vv_seen   = 0;
  int unsigned err_seen  = 0;
  int unsigned drop_seen = 0;
  int unsigned tx_seen   = 0;

  always @(negedge clk) begin
    if (bus.value_valid === 1'b1) vv_seen++;
    if (bus.cmd_err === 1'b1) err_seen++;
    if (bus.rx_drop === 1'b1) drop_seen++;
    if (bus.tx_valid === 1'b1) tx_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] resp_char(input bit ok, input int i);
    string s;
    s = ok ? "OK\015\012" : "ER\015\012";
    return s[i];
  endfunction

  task automatic model_byte(input logic [7:0] b, output bit vv, output bit er);
    vv = 1'b0;
    er = 1'b0;
    if (b == 8'h0D) begin
      if (m_err) begin
        er = 1'b1;
      end else if (m_digits.size() > 0) begin
        m_value = '0;
        foreach (m_digits[i]) m_value = m_value * 16 + VALUE_W'(m_digits[i]);
        vv = 1'b1;
      end
      m_digits.delete();
      m_err = 1'b0;
    end else if (hex_val(b) >= 0) begin
      if (!m_err) begin
        if (m_digits.size() < int'(DIGITS)) m_digits.push_back(hex_val(b));
        else m_err = 1'b1;
      end
    end else if (b == 8'h08) begin
      if (!m_err && m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (b != 8'h0A && b != 8'h20) begin
      m_err = 1'b1;
    end
  endtask

  task automatic drain(input bit ok);
    for (int i = 0; i < 4; i++) begin
      check("resp_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("resp_tx_data", 32'(bus.tx_data), 32'(resp_char(ok, i)));
      bus.tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.tx_ready = 1'b0;
    end
    check("resp_done_tx_valid", 32'(bus.tx_valid), 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with outputs of that byte settled.
  task automatic send_byte(input logic [7:0] b, input bit auto_drain);
    bit vv, er;
    model_byte(b, vv, er);
    if (vv) exp_vv++;
    if (er) exp_err++;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("value_valid", 32'(bus.value_valid), 32'(vv));
    check("cmd_err", 32'(bus.cmd_err), 32'(er));
    check("value", 32'(bus.value), 32'(m_value));
    check("digit_cnt", 32'(bus.digit_cnt), 32'(m_digits.size()));
`ifdef ASCII_HEX_ACK_EN
    if ((vv || er) && auto_drain) drain(vv);
`else
    if (b == 8'h0D) check("tx_valid_off", 32'(bus.tx_valid), 32'd0);
    if (auto_drain) repeat ($urandom_range(0, 1)) @(negedge clk);
`endif
  endtask

  task automatic send_str(input string s, input bit auto_drain);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], auto_drain);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_value", 32'(bus.value), 32'd0);
    check("rst_digit_cnt", 32'(bus.digit_cnt), 32'd0);
    check("rst_value_valid", 32'(bus.value_valid), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    rst_n = 1'b1;
    m_digits.delete();
    m_err   = 1'b0;
    m_value = '0;
  endtask

  function automatic logic [7:0] rand_char();
    string hexset;
    int    r;
    logic [7:0] b;
    hexset = "0123456789abcdefABCDEF";
    r = int'($urandom_range(0, 99));
    if (r < 65) return hexset[$urandom_range(0, 21)];
    if (r < 75) return 8'h08;
    if (r < 80) return 8'h20;
    if (r < 85) return 8'h0A;
    for (int t = 0; t < 100; t++) begin
      b = 8'($urandom_range(0, 255));
      if (hex_val(b) < 0 && b != 8'h0D && b != 8'h08 && b != 8'h0A && b != 8'h20) return b;
    end
    return "G";
  endfunction

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    do_reset();

    send_str("1123\015", 1'b1);
    check("dir_1123", 32'(bus.value), 32'h1123);
    send_str("1193\015", 1'b1);
    check("dir_1193", 32'(bus.value), 32'h1193);
    send_str("1010\015", 1'b1);
    check("dir_1010", 32'(bus.value), 32'h1010);
    send_str("12G4\015", 1'b1);
    check("dir_bad_held", 32'(bus.value), 32'h1010);
    send_str("00ff\015", 1'b1);
    check("dir_00ff", 32'(bus.value), 32'h00FF);
    send_str("12345\015", 1'b1);
    check("dir_overflow_held", 32'(bus.value), 32'h00FF);
    send_str("12\0103\015", 1'b1);
    check("dir_bs", 32'(bus.value), 32'h0013);
    send_str("\015", 1'b1);
    check("dir_lone_cr", 32'(bus.value), 32'h0013);
    send_str("1 2\0123\015", 1'b1);
    check("dir_ws", 32'(bus.value), 32'h0123);
    send_str("a\010\010B\015", 1'b1);
    check("dir_bs_at_zero", 32'(bus.value), 32'h000B);
    check("dir_pulses", vv_seen, 32'd7);
    check("dir_errs", err_seen, 32'd2);

    // Reset in the middle of a command.
    send_str("12", 1'b1);
    check("mid_cnt", 32'(bus.digit_cnt), 32'd2);
    do_reset();

`ifdef ASCII_HEX_ACK_EN
    // Stalled response: byte held, incoming bytes dropped.
    send_str("1123\015", 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("hold_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("hold_tx_data", 32'(bus.tx_data), 32'h4F);
      @(negedge clk);
    end
    bus.rx_data  = "7";
    bus.rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    exp_drop++;
    check("drop_pulse", 32'(bus.rx_drop), 32'd1);
    check("drop_cnt", 32'(bus.digit_cnt), 32'd0);
    check("drop_value", 32'(bus.value), 32'h1123);
    drain(1'b1);
    // Reset in the middle of a response.
    send_str("55\015", 1'b0);
    check("midresp_tx_valid", 32'(bus.tx_valid), 32'd1);
    do_reset();
`endif

    for (int c = 0; c < 60; c++) begin
      int len;
      len = int'($urandom_range(0, 6));
      for (int k = 0; k < len; k++) send_byte(rand_char(), 1'b1);
      send_byte(8'h0D, 1'b1);
    end

    @(negedge clk);
    check("total_value_valid", vv_seen, exp_vv);
    check("total_cmd_err", err_seen, exp_err);
    check("total_rx_drop", drop_seen, exp_drop);
`ifndef ASCII_HEX_ACK_EN
    check("total_tx_valid", tx_seen, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
